// File: rtl/carfield_mbox_pkg.sv
// ============================================================================
// Module   : carfield_mbox_pkg
// Brief    : Register offsets, STATUS bit positions and FSM state encoding
//            shared by the mailbox responder and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package carfield_mbox_pkg;

    localparam logic [4:0] DataWOff   = 5'h00;
    localparam logic [4:0] DataROff   = 5'h04;
    localparam logic [4:0] StatusOff  = 5'h08;
    localparam logic [4:0] IrqEnOff   = 5'h0C;
    localparam logic [4:0] IrqClrOff  = 5'h10;
    localparam logic [4:0] DropCntOff = 5'h14;

    localparam int unsigned MboxStride = 32'h20;

    localparam int unsigned StatusEmptyBit = 0;
    localparam int unsigned StatusFullBit  = 1;
    localparam int unsigned StatusPendBit  = 2;
    localparam int unsigned StatusCntLsb   = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StResp = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/carfield_mbox_fifo.sv
// ============================================================================
// Module   : carfield_mbox_fifo
// Brief    : Single-clock word FIFO with head-of-queue output and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carfield_mbox_fifo #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned Width    = 32,
    localparam int unsigned PtrWidth = $clog2(Depth),
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic                pop_i,
    output logic [Width-1:0]    head_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = (count == CntWidth'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            count <= count + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/carfield_mbox_responder.sv
// ============================================================================
// Module   : carfield_mbox_responder
// Brief    : RegBus mailbox window: NumMbox word FIFOs with per-mailbox IRQ.
//            Define CARFIELD_MBOX_DROP_CNT_EN to add the 0x14 drop counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carfield_mbox_responder
    import carfield_mbox_pkg::*;
#(
    parameter int unsigned NumMbox   = 4,
    parameter int unsigned Depth     = 4,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 req_ready_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NumMbox-1:0]   irq_o
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);

    state_e                           state;
    logic [6:0]                       mbox_idx;
    logic [4:0]                       offset;
    logic                             fire;
    logic                             unused_addr;

    logic [NumMbox-1:0]               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [NumMbox-1:0][CntWidth-1:0] fifo_count;
    logic [NumMbox-1:0][31:0]         fifo_head;
    logic [NumMbox-1:0]               pending, irq_en, pend_set, pend_clr, en_wr;

    logic                             hit, sel_full, sel_empty, sel_pend, sel_en;
    logic [CntWidth-1:0]              sel_count;
    logic [31:0]                      sel_head;
    logic                             acc_err, do_push, do_pop, do_en_wr, do_clr;
    logic [31:0]                      acc_rdata;

`ifdef CARFIELD_MBOX_DROP_CNT_EN
    logic [NumMbox-1:0][7:0]          drop_cnt;
    logic [NumMbox-1:0]               drop_inc, drop_clr;
    logic [7:0]                       sel_drop;
    logic                             do_drop_inc, do_drop_clr;
`endif

    assign mbox_idx    = req_addr_i[11:5];
    assign offset      = req_addr_i[4:0];
    assign fire        = (state == StIdle) && req_valid_i;
    assign unused_addr = ^req_addr_i[AddrWidth-1:12];

    for (genvar k = 0; k < NumMbox; k++) begin : g_mbox
        carfield_mbox_fifo #(
            .Depth (Depth),
            .Width (32)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (fifo_push[k]),
            .wdata_i (req_wdata_i),
            .pop_i   (fifo_pop[k]),
            .head_o  (fifo_head[k]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k]),
            .count_o (fifo_count[k])
        );
    end

    always_comb begin
        hit       = 1'b0;
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_pend  = 1'b0;
        sel_en    = 1'b0;
        sel_count = '0;
        sel_head  = '0;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
        sel_drop  = '0;
`endif
        for (int k = 0; k < NumMbox; k++) begin
            if (int'(mbox_idx) == k) begin
                hit       = 1'b1;
                sel_full  = fifo_full[k];
                sel_empty = fifo_empty[k];
                sel_pend  = pending[k];
                sel_en    = irq_en[k];
                sel_count = fifo_count[k];
                sel_head  = fifo_head[k];
`ifdef CARFIELD_MBOX_DROP_CNT_EN
                sel_drop  = drop_cnt[k];
`endif
            end
        end
    end

    // Access decode: every rejected access leaves all state untouched.
    always_comb begin
        acc_err   = 1'b0;
        acc_rdata = '0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_en_wr  = 1'b0;
        do_clr    = 1'b0;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
        do_drop_inc = 1'b0;
        do_drop_clr = 1'b0;
`endif
        if ((req_addr_i[1:0] != 2'b00) || !hit) begin
            acc_err = 1'b1;
        end else begin
            case (offset)
                DataWOff: begin
                    if (!req_write_i || (req_wstrb_i != 4'hF)) begin
                        acc_err = 1'b1;
                    end else if (sel_full) begin
                        acc_err = 1'b1;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
                        do_drop_inc = 1'b1;
`endif
                    end else begin
                        do_push = 1'b1;
                    end
                end
                DataROff: begin
                    if (req_write_i || sel_empty) begin
                        acc_err = 1'b1;
                    end else begin
                        do_pop    = 1'b1;
                        acc_rdata = sel_head;
                    end
                end
                StatusOff: begin
                    if (req_write_i) begin
                        acc_err = 1'b1;
                    end else begin
                        acc_rdata[StatusEmptyBit]       = sel_empty;
                        acc_rdata[StatusFullBit]        = sel_full;
                        acc_rdata[StatusPendBit]        = sel_pend;
                        acc_rdata[StatusCntLsb +: 8]    = 8'(sel_count);
                    end
                end
                IrqEnOff: begin
                    if (req_write_i) do_en_wr = req_wstrb_i[0];
                    else             acc_rdata[0] = sel_en;
                end
                IrqClrOff: begin
                    if (req_write_i) do_clr = req_wstrb_i[0] && req_wdata_i[0];
                end
`ifdef CARFIELD_MBOX_DROP_CNT_EN
                DropCntOff: begin
                    if (req_write_i) do_drop_clr = 1'b1;
                    else             acc_rdata[7:0] = sel_drop;
                end
`endif
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        pend_set  = '0;
        pend_clr  = '0;
        en_wr     = '0;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
        drop_inc  = '0;
        drop_clr  = '0;
`endif
        for (int k = 0; k < NumMbox; k++) begin
            if (fire && (int'(mbox_idx) == k)) begin
                fifo_push[k] = do_push;
                fifo_pop[k]  = do_pop;
                pend_set[k]  = do_push;
                pend_clr[k]  = do_clr;
                en_wr[k]     = do_en_wr;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
                drop_inc[k]  = do_drop_inc;
                drop_clr[k]  = do_drop_clr;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= StIdle;
            req_ready_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
            pending     <= '0;
            irq_en      <= '0;
            irq_o       <= '0;
        end else begin
            irq_o   <= pending & irq_en;
            pending <= (pending | pend_set) & ~pend_clr;
            irq_en  <= (irq_en & ~en_wr) | (en_wr & {NumMbox{req_wdata_i[0]}});
            case (state)
                StIdle: begin
                    req_ready_o <= 1'b0;
                    if (req_valid_i) begin
                        state       <= StResp;
                        req_ready_o <= 1'b1;
                        rsp_rdata_o <= acc_err ? 32'h0 : acc_rdata;
                        rsp_error_o <= acc_err;
                    end
                end
                StResp: begin
                    state       <= StIdle;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef CARFIELD_MBOX_DROP_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else begin
            for (int k = 0; k < NumMbox; k++) begin
                if (drop_clr[k])
                    drop_cnt[k] <= 8'h00;
                else if (drop_inc[k] && (drop_cnt[k] != 8'hFF))
                    drop_cnt[k] <= drop_cnt[k] + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_carfield_mbox_responder.sv
// ============================================================================
// Module   : tb_carfield_mbox_responder
// Brief    : Directed and randomized bench for the mailbox responder against a
//            queue-based reference model (honours CARFIELD_MBOX_DROP_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_carfield_mbox_responder;

    localparam int NMBOX = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [3:0]       req_wstrb;
    logic             req_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_error;
    logic [NMBOX-1:0] irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [NMBOX][$];
    bit          mpend [NMBOX];
    bit          men   [NMBOX];
    int          mdrop [NMBOX];

    logic [31:0] last_rd;
    logic        last_er;

    always #5 clk = ~clk;

    carfield_mbox_responder #(
        .NumMbox   (NMBOX),
        .Depth     (DEPTH),
        .AddrWidth (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_ready_o (req_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .irq_o       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NMBOX; k++) begin
            mq[k].delete();
            mpend[k] = 1'b0;
            men[k]   = 1'b0;
            mdrop[k] = 0;
        end
    endfunction

    function automatic logic [NMBOX-1:0] model_irq();
        logic [NMBOX-1:0] v;
        for (int k = 0; k < NMBOX; k++) v[k] = mpend[k] & men[k];
        return v;
    endfunction

    // Behavioural view of one access: returns the expected response, updates the model.
    function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] ws, output logic [31:0] rd, output logic er);
        int m   = int'(addr[11:5]);
        int off = int'(addr[4:0]);
        rd = 32'h0;
        er = 1'b0;
        if (addr[1:0] != 2'b00 || m >= NMBOX) begin
            er = 1'b1;
        end else if (off == 'h00) begin
            if (!wr || ws != 4'hF) er = 1'b1;
            else if (mq[m].size() == DEPTH) begin
                er = 1'b1;
                if (mdrop[m] < 255) mdrop[m]++;
            end else begin
                mq[m].push_back(wd);
                mpend[m] = 1'b1;
            end
        end else if (off == 'h04) begin
            if (wr || mq[m].size() == 0) er = 1'b1;
            else rd = mq[m].pop_front();
        end else if (off == 'h08) begin
            if (wr) er = 1'b1;
            else rd = mq[m].size() * 256 + (mpend[m] ? 4 : 0)
                      + (mq[m].size() == DEPTH ? 2 : 0) + (mq[m].size() == 0 ? 1 : 0);
        end else if (off == 'h0C) begin
            if (wr) begin
                if (ws[0]) men[m] = wd[0];
            end else rd = men[m] ? 32'h1 : 32'h0;
        end else if (off == 'h10) begin
            if (wr && ws[0] && wd[0]) mpend[m] = 1'b0;
`ifdef CARFIELD_MBOX_DROP_CNT_EN
        end else if (off == 'h14) begin
            if (wr) mdrop[m] = 0;
            else rd = 32'(mdrop[m]);
`endif
        end else begin
            er = 1'b1;
        end
    endfunction

    task automatic acc(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat = 0;
        bit          got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (req_ready === 1'b1) got = 1'b1;
        end
        last_rd   = rsp_rdata;
        last_er   = rsp_error;
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL timeout: no ready for addr %h within 8 cycles", addr);
        end else begin
            model(wr, addr, wd, ws, exp_rd, exp_er);
            chk("latency", 32'(lat), 32'd1);
            chk($sformatf("rdata@%h", addr), rsp_rdata, exp_rd);
            chk($sformatf("error@%h", addr), 32'(rsp_error), 32'(exp_er));
        end
        @(posedge clk);
        #1;
        chk("ready_low_after", 32'(req_ready), 32'd0);
        chk("irq", 32'(irq), 32'(model_irq()));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_error", 32'(rsp_error), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        acc(1'b0, 32'h008, 32'h0, 4'hF);
        chk("status0_reset", last_rd, 32'h0000_0001);

        acc(1'b1, 32'h02C, 32'h1, 4'hF);
        acc(1'b1, 32'h020, 32'hDEADBEEF, 4'hF);
        chk("irq1_set", 32'(irq[1]), 32'd1);
        acc(1'b0, 32'h024, 32'h0, 4'hF);
        chk("pop1", last_rd, 32'hDEADBEEF);
        acc(1'b0, 32'h028, 32'h0, 4'hF);
        chk("status1", last_rd, 32'h0000_0005);
        acc(1'b1, 32'h030, 32'h1, 4'hF);
        chk("irq1_clr", 32'(irq[1]), 32'd0);

        for (int i = 1; i <= 4; i++) acc(1'b1, 32'h040, 32'(i), 4'hF);
        acc(1'b0, 32'h048, 32'h0, 4'hF);
        chk("status2_full", last_rd, 32'h0000_0406);
        acc(1'b1, 32'h040, 32'd5, 4'hF);
        chk("push_full_err", 32'(last_er), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            acc(1'b0, 32'h044, 32'h0, 4'hF);
            chk("pop2_order", last_rd, 32'(i));
        end
        acc(1'b0, 32'h044, 32'h0, 4'hF);
        chk("pop_empty_err", 32'(last_er), 32'd1);
        chk("pop_empty_rdata", last_rd, 32'h0);

        acc(1'b0, 32'h002, 32'h0, 4'hF);
        chk("misaligned", 32'(last_er), 32'd1);
        acc(1'b0, 32'h080, 32'h0, 4'hF);
        chk("bad_mbox", 32'(last_er), 32'd1);
        acc(1'b1, 32'h008, 32'hFFFF_FFFF, 4'hF);
        chk("write_status", 32'(last_er), 32'd1);
        acc(1'b1, 32'h000, 32'h1234_5678, 4'h3);
        chk("partial_strobe", 32'(last_er), 32'd1);
        acc(1'b0, 32'h008, 32'h0, 4'hF);
        chk("no_state_change", last_rd, 32'h0000_0001);

`ifdef CARFIELD_MBOX_DROP_CNT_EN
        for (int i = 0; i < 7; i++) acc(1'b1, 32'h000, $urandom, 4'hF);
        acc(1'b0, 32'h014, 32'h0, 4'hF);
        chk("drop_3", last_rd, 32'd3);
        for (int i = 0; i < 300; i++) acc(1'b1, 32'h000, $urandom, 4'hF);
        acc(1'b0, 32'h014, 32'h0, 4'hF);
        chk("drop_sat", last_rd, 32'hFF);
        acc(1'b1, 32'h014, 32'h5A, 4'h0);
        acc(1'b0, 32'h014, 32'h0, 4'hF);
        chk("drop_clr", last_rd, 32'd0);
`else
        acc(1'b0, 32'h014, 32'h0, 4'hF);
        chk("drop_unmapped", 32'(last_er), 32'd1);
`endif

        // Reset landing in the response cycle of a push.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h060;
        req_wdata = 32'hCAFE_F00D;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        chk("resp_before_reset", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_aborted", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        acc(1'b0, 32'h068, 32'h0, 4'hF);
        chk("status3_after_reset", last_rd, 32'h0000_0001);

        for (int i = 0; i < 400; i++) begin
            int          m   = $urandom_range(0, NMBOX);
            int          sel = $urandom_range(0, 8);
            int          off = (sel == 8) ? 1 : sel * 4;
            bit          wr  = $urandom_range(0, 1);
            logic [3:0]  ws  = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom);
            acc(wr, 32'(m * 32 + off), $urandom, ws);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/carfield_mbox_responder.md
Name: carfield_mbox_responder

Overview:
- Register-bus target implementing the mailbox window (base 0x4000_0000, 4 KiB) that the host-side address map routes to.
- Holds NumMbox independent 32-bit word FIFOs. Senders push via register writes; receivers pop via register reads.
- Raises one level interrupt per mailbox towards the receiving domain.
- Sits behind the RegBus demux; decodes only addr_i[11:0].

Parameters:
- NumMbox, 4, number of mailboxes (1..64).
- Depth, 4, words per mailbox FIFO (power of two, >=2).
- AddrWidth, 32, reg-bus address width.
- CntWidth, $clog2(Depth+1), derived, FIFO occupancy width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  access request, held until req_ready_o.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  AddrWidth  byte address; only [11:0] used.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte strobes.
- req_ready_o  out  1  response/completion strobe.
- rsp_rdata_o  out  32  read data, valid with req_ready_o.
- rsp_error_o  out  1  access error, valid with req_ready_o.
- irq_o  out  NumMbox  per-mailbox interrupt, level.

Behaviour:
- Reset is synchronous, active-low, on clk_i rising edge. Reset clears all FIFOs, pending=0, irq_en=0, FSM=IDLE, and all outputs (req_ready_o, rsp_rdata_o, rsp_error_o, irq_o) to 0.
- Register map, per mailbox k at offset k*0x20:
  - 0x00 DATA_W: write-only, push.
  - 0x04 DATA_R: read-only, pop.
  - 0x08 STATUS: RO. bit0 empty, bit1 full, bit2 pending, [15:8] count.
  - 0x0C IRQ_EN: RW, bit0.
  - 0x10 IRQ_CLR: write bit0=1 clears pending; reads return 0.
  - 0x14: see optional feature.
  - Other offsets are unmapped.
- FSM has two states:
  - IDLE: on req_valid_i, decode and perform the side effect at this edge (push, pop, register update). Register rdata and error, go to RESP.
  - RESP: req_ready_o=1 for exactly one cycle, then IDLE.
  - Latency is 1 cycle from valid to ready. Throughput is one access per 2 cycles. req_ready_o is never high in IDLE.
- Error (rsp_error_o=1, no state change, rdata=0) on any of:
  - req_addr_i[1:0]!=0;
  - mailbox index >= NumMbox;
  - unmapped offset;
  - write to DATA_R or STATUS;
  - read of DATA_W;
  - DATA_W write with wstrb!=4'hF;
  - push when full;
  - pop when empty.
- IRQ_EN and IRQ_CLR honour wstrb[0]; no other strobe restriction applies.
- Push: the word is appended and pending is set the same edge. Pop: the head word is returned. FIFO pointers wrap modulo Depth.
- A push that makes count==Depth sets full. A pop from count==1 sets empty. pending is unaffected by pops.
- irq_o[k] = pending[k] & irq_en[k], registered: it updates the cycle after the state change.
- Reset asserted in RESP aborts the response: req_ready_o=0 next cycle. A side effect already performed stays lost, because state is cleared.

Optional Feature:
- Macro CARFIELD_MBOX_DROP_CNT_EN.
- Defined:
  - Each mailbox has an 8-bit saturating drop counter, readable at offset 0x14.
  - It increments on every rejected push-when-full and holds at 0xFF.
  - Any write to 0x14 clears it; wdata is ignored.
- Undefined: offset 0x14 is unmapped (error), and no counter logic is present.

Decomposition:
- Package carfield_mbox_pkg holds:
  - offset constants (DataWOff, DataROff, StatusOff, IrqEnOff, IrqClrOff, DropCntOff);
  - MboxStride=0x20;
  - STATUS bit-position constants;
  - the FSM state enum.
- Sub-module carfield_mbox_fifo: a single-clock FIFO with push/pop/full/empty/count, instantiated NumMbox times via generate.

Test Plan:
- Reset, then read STATUS of mbox0 (0x008) -> rdata=0x0000_0001, error=0, irq_o=0.
- IRQ_EN mbox1=1, then write 0xDEADBEEF to 0x020 -> irq_o[1]=1 one cycle after ready. Read 0x024 -> 0xDEADBEEF. STATUS 0x028 -> 0x0000_0005 (empty+pending). Write 1 to 0x030 -> irq_o[1]=0.
- Push 4 words (1,2,3,4) to mbox2, then a 5th (5) -> 5th error=1. Pops return 1,2,3,4 in order; a 5th pop gives error=1, rdata=0. STATUS after the 4 pushes = 0x0000_0406.
- Error cases, each error=1 with no state change:
  - addr 0x002 (misaligned);
  - addr 0x080 with NumMbox=4;
  - write to 0x008;
  - wstrb=4'h3 on 0x000.
- With CARFIELD_MBOX_DROP_CNT_EN: fill mbox0, then 3 extra pushes -> 0x014 reads 3. After 300 extra pushes it reads 0xFF. A write clears it to 0. Without the macro, a read of 0x014 gives error=1.
- Assert rst_ni during RESP after a push -> req_ready_o=0 next cycle, STATUS afterwards reads empty.
